// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with a per-register
// busy scoreboard. Register 0 is hard-wired to zero and is never busy.
// Reads are combinational. Writeback data is stored on the rising edge.
// With BYPASS=1, writeback data is also forwarded to reads in the same cycle.
// The issue stage sets busy bits, writeback clears them, and flush clears all.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRD-1:0][AW-1:0]    ra,
  output logic [NRD-1:0][XLEN-1:0]  rd,
  output logic [NRD-1:0]            rd_busy,
  input  logic                      we,
  input  logic [AW-1:0]             wa,
  input  logic [XLEN-1:0]           wd,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_rd,
  input  logic                      flush,
  output logic                      busy_any
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0]  data_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // A writeback is effective only when it targets a real register.
  logic wr_en;
  assign wr_en = we && (wa != '0);

  // Data array: reset clears every entry; entry 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en && (wa == AW'(i))) begin
          data_q[i] <= wd;
        end
      end
    end
  end

  // Busy next state: flush beats issue, and issue beats writeback.
  // Writeback clears first so that an issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en) begin
        busy_d[wa] = 1'b0;
      end
      if (iss_valid && (iss_rd != '0)) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read ports. Outputs are gated by reset, so a same-cycle bypass cannot
  // leak out while reset is held low. A same-cycle writeback hides the busy
  // bit unless a same-cycle issue re-targets the register.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (reset && (ra[k] != '0)) begin
        if (BYP && we && (wa == ra[k])) begin
          rd[k] = wd;
        end else begin
          rd[k] = data_q[ra[k]];
        end
        if (BYP && we && (wa == ra[k]) && !(iss_valid && (iss_rd == ra[k]))) begin
          rd_busy[k] = 1'b0;
        end else begin
          rd_busy[k] = busy_q[ra[k]];
        end
      end
    end
  end

  assign busy_any = |busy_q;

endmodule
